// File: rtl/link_upstream_ddr_multi.sv
// Multi-channel upstream DDR link serializer: FIFO-buffered core words are
// sent as two phases across NUM_CH channels, gated by a token-refilled credit pool.
module link_upstream_ddr_multi #(
  parameter int NUM_CH      = 2,
  parameter int CH_WIDTH    = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_CREDITS = 64,
  parameter int TOKEN_BATCH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [2*NUM_CH*CH_WIDTH-1:0]         core_data_i,
  input  logic                                 core_valid_i,
  output logic                                 core_ready_o,
  input  logic                                 token_i,
  output logic [NUM_CH*CH_WIDTH-1:0]           io_data_o,
  output logic                                 io_valid_o,
  output logic                                 io_phase_o,
  output logic [$clog2(MAX_CREDITS):0]         credits_o,
  output logic [$clog2(FIFO_DEPTH):0]          fifo_count_o,
  output logic                                 overflow_err_o
);

  localparam int IOW = NUM_CH * CH_WIDTH;
  localparam int WW  = 2 * IOW;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int KW  = $clog2(MAX_CREDITS) + 1;
  localparam int SW  = KW + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH0  = 2'd1,
    PH1  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [WW-1:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wptr_q, rptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic [KW-1:0]  credits_q, credits_d;
  logic           ovf_q, ovf_d;
  logic [WW-1:0]  word_q, word_d;
  logic [IOW-1:0] data_q, data_d;
  logic           valid_q, valid_d;
  logic           phase_q, phase_d;
  logic [SW-1:0]  sum;
  logic           push, pop, can_send, over;

  assign core_ready_o   = (count_q != CW'(FIFO_DEPTH));
  assign push           = core_valid_i && core_ready_o;
  assign can_send       = (count_q != '0) && (credits_q != '0);
  assign io_data_o      = data_q;
  assign io_valid_o     = valid_q;
  assign io_phase_o     = phase_q;
  assign credits_o      = credits_q;
  assign fifo_count_o   = count_q;
  assign overflow_err_o = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (can_send) begin
          pop     = 1'b1;
          state_d = PH0;
        end
      end
      PH0: state_d = PH1;
      PH1: begin
        if (can_send) begin
          pop     = 1'b1;
          state_d = PH0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next state.
  always_comb begin
    word_d  = pop ? mem_q[rptr_q] : word_q;
    valid_d = 1'b0;
    phase_d = 1'b0;
    data_d  = '0;
    unique case (state_d)
      PH0: begin
        valid_d = 1'b1;
        data_d  = word_d[IOW-1:0];
      end
      PH1: begin
        valid_d = 1'b1;
        phase_d = 1'b1;
        data_d  = word_d[WW-1:IOW];
      end
      default: ;
    endcase
  end

  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
    sum     = {2'b00, credits_q} - SW'(pop)
            + (token_i ? SW'(TOKEN_BATCH) : '0);
    over    = (sum > SW'(MAX_CREDITS));
    credits_d = over ? KW'(MAX_CREDITS) : sum[KW-1:0];
    ovf_d   = ovf_q | over;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= core_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      credits_q <= KW'(MAX_CREDITS);
      ovf_q     <= 1'b0;
      word_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      phase_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      count_q   <= count_d;
      credits_q <= credits_d;
      ovf_q     <= ovf_d;
      word_q    <= word_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      phase_q   <= phase_d;
    end
  end

endmodule

// File: tb/tb_link_upstream_ddr_multi.sv
// Bench for link_upstream_ddr_multi: directed scenarios plus random traffic,
// with accepted words queued as expected beats and checked by a monitor.
module tb_link_upstream_ddr_multi;

  localparam int NUM_CH = 2;
  localparam int CH_WIDTH = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_CREDITS = 64;
  localparam int TOKEN_BATCH = 8;
  localparam int IOW = NUM_CH * CH_WIDTH;
  localparam int WW = 2 * IOW;

  logic clk, rst;
  logic [WW-1:0] core_data_i;
  logic core_valid_i, core_ready_o, token_i;
  logic [IOW-1:0] io_data_o;
  logic io_valid_o, io_phase_o;
  logic [$clog2(MAX_CREDITS):0] credits_o;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_o;
  logic overflow_err_o;

  link_upstream_ddr_multi #(
    .NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .FIFO_DEPTH(FIFO_DEPTH),
    .MAX_CREDITS(MAX_CREDITS), .TOKEN_BATCH(TOKEN_BATCH)
  ) dut (
    .clk(clk), .rst(rst),
    .core_data_i(core_data_i), .core_valid_i(core_valid_i),
    .core_ready_o(core_ready_o), .token_i(token_i),
    .io_data_o(io_data_o), .io_valid_o(io_valid_o),
    .io_phase_o(io_phase_o), .credits_o(credits_o),
    .fifo_count_o(fifo_count_o), .overflow_err_o(overflow_err_o)
  );

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int ph0_cnt = 0;
  int ph1_cnt = 0;
  logic [IOW:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every accepted word becomes two expected beats; reset discards them.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else if (core_valid_i && core_ready_o) begin
      exp_q.push_back({1'b0, core_data_i[IOW-1:0]});
      exp_q.push_back({1'b1, core_data_i[WW-1:IOW]});
      acc_cnt++;
    end
  end

  always @(negedge clk) begin
    if (io_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat: got %0h with no beat expected",
                 {io_phase_o, io_data_o});
      end else begin
        logic [IOW:0] e;
        e = exp_q.pop_front();
        chk("beat", {io_phase_o, io_data_o}, e);
        if (e[IOW]) ph1_cnt++;
        else ph0_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(logic [WW-1:0] w);
    int n;
    core_data_i = w;
    core_valid_i = 1'b1;
    n = 0;
    while (!core_ready_o && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: ready low for %0d cycles", n);
    end
    tick();
    core_valid_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base0, acc0, ntok, n;
    logic [WW-1:0] w;
    rst = 1'b1;
    core_data_i = '0;
    core_valid_i = 1'b0;
    token_i = 1'b0;
    ticks(2);
    chk("rst_ready", core_ready_o, 1);
    chk("rst_valid", io_valid_o, 0);
    chk("rst_phase", io_phase_o, 0);
    chk("rst_data", io_data_o, 0);
    chk("rst_credits", credits_o, MAX_CREDITS);
    chk("rst_count", fifo_count_o, 0);
    chk("rst_ovf", overflow_err_o, 0);
    rst = 1'b0;
    tick();

    // Single word
    push(32'hDDCCBBAA);
    chk("t1_count", fifo_count_o, 1);
    chk("t1_valid_early", io_valid_o, 0);
    tick();
    chk("t1_credits", credits_o, 63);
    chk("t1_ph0_valid", io_valid_o, 1);
    chk("t1_ph0", {io_phase_o, io_data_o}, {1'b0, 16'hBBAA});
    tick();
    chk("t1_ph1", {io_valid_o, io_phase_o, io_data_o}, {2'b11, 16'hDDCC});
    tick();
    chk("t1_idle", io_valid_o, 0);

    // Credit exhaustion
    do_reset();
    base = ph1_cnt;
    for (int i = 0; i < 66; i++) push(WW'(32'h1000_0000 + i * 32'h0101_0101));
    ticks(10);
    chk("t2_words", ph1_cnt - base, 64);
    chk("t2_credits", credits_o, 0);
    chk("t2_count", fifo_count_o, 2);
    chk("t2_valid", io_valid_o, 0);
    token_i = 1'b1;
    tick();
    token_i = 1'b0;
    chk("t2_tok_credits", credits_o, 8);
    ticks(10);
    chk("t2_credits_end", credits_o, 6);
    chk("t2_words_end", ph1_cnt - base, 66);
    chk("t2_count_end", fifo_count_o, 0);

    // Overflow
    do_reset();
    token_i = 1'b1;
    tick();
    token_i = 1'b0;
    chk("t3_credits", credits_o, 64);
    chk("t3_ovf", overflow_err_o, 1);
    tick();
    chk("t3_ovf_hold", overflow_err_o, 1);
    do_reset();
    chk("t3_ovf_clr", overflow_err_o, 0);

    // FIFO full and back-pressure
    for (int i = 0; i < 64; i++) push(WW'($urandom));
    ticks(10);
    chk("t4_drained", credits_o, 0);
    for (int i = 0; i < 4; i++) push(WW'(32'hA5A5_0000 + i));
    chk("t4_full", fifo_count_o, 4);
    chk("t4_ready_lo", core_ready_o, 0);
    core_data_i = WW'(32'h5A5A_1234);
    core_valid_i = 1'b1;
    ticks(2);
    chk("t4_hold_count", fifo_count_o, 4);
    token_i = 1'b1;
    tick();
    token_i = 1'b0;
    chk("t4_tok_credits", credits_o, 8);
    chk("t4_ready_still_lo", core_ready_o, 0);
    tick();
    chk("t4_ready_hi", core_ready_o, 1);
    chk("t4_count_pop", fifo_count_o, 3);
    tick();
    core_valid_i = 1'b0;
    chk("t4_refill", fifo_count_o, 4);
    ticks(12);
    chk("t4_credits_end", credits_o, 3);
    chk("t4_count_end", fifo_count_o, 0);

    // Simultaneous pop and token
    push(WW'(32'h0BAD_F00D));
    push(WW'(32'h0C0F_FEE0));
    ticks(10);
    chk("t5_one_credit", credits_o, 1);
    core_data_i = WW'(32'h7777_8888);
    core_valid_i = 1'b1;
    tick();
    core_valid_i = 1'b0;
    token_i = 1'b1;
    tick();
    token_i = 1'b0;
    chk("t5_credits", credits_o, 8);
    chk("t5_count", fifo_count_o, 0);
    chk("t5_valid", io_valid_o, 1);
    ticks(4);

    // Reset mid-word
    do_reset();
    for (int i = 0; i < 6; i++) begin
      core_data_i = WW'(32'hC0DE_0000 + i);
      core_valid_i = 1'b1;
      tick();
    end
    core_valid_i = 1'b0;
    chk("t6_queued", fifo_count_o, 3);
    chk("t6_ph0", {io_valid_o, io_phase_o}, 2'b10);
    rst = 1'b1;
    tick();
    chk("t6_valid", io_valid_o, 0);
    chk("t6_phase", io_phase_o, 0);
    chk("t6_count", fifo_count_o, 0);
    chk("t6_credits", credits_o, 64);
    rst = 1'b0;
    ticks(2);
    chk("t6_quiet", io_valid_o, 0);
    push(WW'(32'h1234_5678));
    tick();
    chk("t6_restart", {io_valid_o, io_phase_o, io_data_o}, {2'b10, 16'h5678});
    ticks(3);

    // Random traffic with tokens that never exceed the pool
    do_reset();
    base0 = ph0_cnt;
    acc0 = acc_cnt;
    ntok = 0;
    for (int i = 0; i < 600; i++) begin
      core_valid_i = 1'($urandom_range(0, 1));
      core_data_i = WW'({$urandom, $urandom});
      token_i = (TOKEN_BATCH * ntok + TOKEN_BATCH <= ph0_cnt - base0)
                && ($urandom_range(0, 3) == 0);
      if (token_i) ntok++;
      tick();
    end
    core_valid_i = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      token_i = (TOKEN_BATCH * ntok + TOKEN_BATCH <= ph0_cnt - base0);
      if (token_i) ntok++;
      tick();
      n++;
    end
    token_i = 1'b0;
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d beats left", exp_q.size());
    end
    ticks(3);
    chk("rnd_credits", credits_o,
        MAX_CREDITS - (acc_cnt - acc0) + TOKEN_BATCH * ntok);
    chk("rnd_count", fifo_count_o, 0);
    chk("rnd_ovf", overflow_err_o, 0);
    chk("rnd_valid", io_valid_o, 0);
    chk("rnd_words", ph0_cnt - base0, acc_cnt - acc0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
